// File: rtl/fir_chain_sequencer.sv
// Sequencer for a cascade of FIR units forming one long filter: loads one
// sample per transaction, strobes every unit together, gathers their done
// pulses, serially sums the partial results and forwards shifted-out samples
// down the chain for the next transaction.
module fir_chain_sequencer #(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned SUM_W         = 2*DATA_SIZE + $clog2(NUM_UNITS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             sample_valid_i,
  input  logic [DATA_SIZE-1:0]             sample_i,
  output logic                             sample_ready_o,
  output logic [NUM_UNITS-1:0]             unit_strobe_o,
  output logic [NUM_UNITS*DATA_SIZE-1:0]   unit_sample_o,
  input  logic [NUM_UNITS-1:0]             unit_done_i,
  input  logic [NUM_UNITS*DATA_SIZE-1:0]   unit_shift_i,
  input  logic [NUM_UNITS*2*DATA_SIZE-1:0] unit_y_i,
  output logic                             y_valid_o,
  output logic [SUM_W-1:0]                 y_o,
  output logic                             busy_o,
  output logic                             err_o,
  input  logic                             err_clr_i
);

  localparam int unsigned Y_W   = 2*DATA_SIZE;
  localparam int unsigned IDX_W = $clog2(NUM_UNITS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SUM    = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  logic [2:0]                            state_q, state_d;
  logic                                  ready_q, busy_q, strobe_q, y_valid_q, err_q;
  logic [SUM_W-1:0]                      y_q, acc_q, acc_sum;
  logic [NUM_UNITS-1:0][DATA_SIZE-1:0]   sample_q;
  logic [NUM_UNITS-1:1][DATA_SIZE-1:0]   chain_q;
  logic [NUM_UNITS-1:0]                  mask_q;
  logic [CNT_W-1:0]                      cnt_q;
  logic [IDX_W-1:0]                      idx_q;

  logic [NUM_UNITS-1:0][DATA_SIZE-1:0]   shift_arr;
  logic [NUM_UNITS-1:0][Y_W-1:0]         y_arr;

  logic accept, wait_clr, cnt_inc, timeout, sum_clr, sum_step, sum_last, out_fire;
  logic all_done;
  logic unused_shift;

  assign shift_arr    = unit_shift_i;
  assign y_arr        = unit_y_i;
  // The last unit's shifted-out sample leaves the filter.
  assign unused_shift = ^shift_arr[NUM_UNITS-1];

  assign all_done = &(mask_q | unit_done_i);
  assign acc_sum  = acc_q + SUM_W'(y_arr[idx_q]);

  assign sample_ready_o = ready_q;
  assign busy_o         = busy_q;
  assign unit_strobe_o  = {NUM_UNITS{strobe_q}};
  assign unit_sample_o  = sample_q;
  assign y_valid_o      = y_valid_q;
  assign y_o            = y_q;
  assign err_o          = err_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wait_clr = 1'b0;
    cnt_inc  = 1'b0;
    timeout  = 1'b0;
    sum_clr  = 1'b0;
    sum_step = 1'b0;
    sum_last = 1'b0;
    out_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wait_clr = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (all_done) begin
          sum_clr = 1'b1;
          state_d = S_SUM;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_SUM: begin
        sum_step = 1'b1;
        if (idx_q == IDX_W'(NUM_UNITS - 1)) begin
          sum_last = 1'b1;
          state_d  = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        out_fire = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status/strobe outputs derived from the upcoming state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      strobe_q  <= (state_d == S_LOAD);
      y_valid_q <= (state_d == S_OUTPUT);
    end
  end

  // Unit input samples and the forwarding chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= '0;
      chain_q  <= '0;
    end else begin
      if (accept) begin
        sample_q[0] <= sample_i;
        for (int unsigned k = 1; k < NUM_UNITS; k++) sample_q[k] <= chain_q[k];
      end
      if (out_fire) begin
        for (int unsigned k = 1; k < NUM_UNITS; k++) chain_q[k] <= shift_arr[k-1];
      end
    end
  end

  // Done-mask collection and WAIT timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (wait_clr) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == S_WAIT) begin
      mask_q <= mask_q | unit_done_i;
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Serial accumulation of the partial sums and final output capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      idx_q <= '0;
      y_q   <= '0;
    end else begin
      if (sum_clr) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (sum_step) begin
        acc_q <= acc_sum;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (sum_last) y_q <= acc_sum;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_q <= 1'b0;
    else if (timeout)   err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

endmodule

// File: doc/fir_chain_sequencer.md
Name: fir_chain_sequencer

Overview:
Sequences a cascade of NUM_UNITS student_fir-style FIR units that together form one long filter. It accepts input samples over a valid/ready handshake and strobes all units together. It forwards each unit's shifted-out oldest sample to the next unit, collects the per-unit one-cycle done pulses, and serially sums the partial results into one filter output. It sits between the sample source and the FIR unit array.

Parameters:
NUM_UNITS, 4, number of cascaded FIR units (>=2)
DATA_SIZE, 16, sample/coefficient width
TIMEOUT_CYCLES, 4096, maximum WAIT cycles before abort
SUM_W, 2*DATA_SIZE+$clog2(NUM_UNITS), output width (derived, localparam)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
sample_valid_i  in  1  input sample valid
sample_i  in  DATA_SIZE  input sample
sample_ready_o  out  1  sequencer can accept a sample
unit_strobe_o  out  NUM_UNITS  per-unit valid strobe, all bits identical
unit_sample_o  out  NUM_UNITS*DATA_SIZE  per-unit input sample; unit k uses slice k
unit_done_i  in  NUM_UNITS  per-unit compute_finished pulse
unit_shift_i  in  NUM_UNITS*DATA_SIZE  per-unit sample_shift_out
unit_y_i  in  NUM_UNITS*2*DATA_SIZE  per-unit partial sum, unsigned
y_valid_o  out  1  one-cycle pulse, y_o is new
y_o  out  SUM_W  filter output
busy_o  out  1  high in any state other than IDLE
err_o  out  1  sticky timeout flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset values (async): state IDLE, sample_ready_o=1, unit_strobe_o=0, unit_sample_o=0, chain registers=0, y_valid_o=0, y_o=0, busy_o=0, err_o=0, done mask=0, accumulator=0.
- States: IDLE, LOAD, WAIT, SUM, OUTPUT.
- IDLE:
  - sample_ready_o=1.
  - A handshake (valid&ready) registers sample_i into unit_sample_o slice 0.
  - Slices 1..N-1 are loaded from chain registers chain_q[1..N-1].
  - Transition to LOAD.
  - Done pulses are ignored.
- LOAD (1 cycle):
  - unit_strobe_o all ones; unit_sample_o is stable in this cycle.
  - Clear the done mask and the timeout counter.
  - Transition to WAIT.
- WAIT:
  - unit_strobe_o=0, which guarantees at least one low cycle between strobes (units are edge-triggered).
  - done_mask |= unit_done_i every cycle.
  - When (done_mask | unit_done_i) is all ones: go to SUM, clear accumulator and index.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: set err_o, go to IDLE, no output, chain registers unchanged.
- SUM (exactly NUM_UNITS cycles):
  - Each cycle acc += unit_y_i[idx], idx runs 0..N-1.
  - Unsigned, zero-extended to SUM_W; SUM_W makes overflow impossible.
  - After idx=N-1, y_o <= final sum and go to OUTPUT.
- OUTPUT (1 cycle):
  - y_valid_o=1.
  - chain_q[k] <= unit_shift_i slice k-1, for k=1..N-1.
  - Return to IDLE.
  - y_o holds until the next OUTPUT.
- Latency:
  - LOAD is the cycle after the handshake.
  - If the final done is observed in WAIT cycle t, y_valid_o is high in cycle t+NUM_UNITS+1.
- sample_ready_o=0 in all non-IDLE states. A sample held valid while not ready is accepted on the first IDLE cycle, never dropped or duplicated.
- Done pulses from a unit repeated in WAIT are harmless (OR mask).
- err_o:
  - Set only by timeout; cleared by err_clr_i.
  - Set wins if both occur in the same cycle.
  - err_o does not block operation.
- Async reset in any state, e.g. mid-SUM: immediate return to IDLE with all reset values. No y_valid_o pulse follows reset.

Test Plan:
- Reset: assert rst_ni low mid-stream -> all outputs 0, sample_ready_o=1, busy_o=0; release -> still idle, no strobe.
- Single sample (N=4): sample_i=0x0010; units return y=100,200,300,400 with done 5/7/9/11 cycles after LOAD -> one strobe cycle, unit_sample_o slices={0x0010,0,0,0}. Required: y_o=1000 and y_valid_o exactly 5 cycles after last done.
- Chain forwarding: after transaction 1, unit_shift slices 0..2 = 0x000A,0x000B,0x000C. Second sample 0x0020 -> unit_sample_o slices={0x0020,0x000A,0x000B,0x000C}.
- Max width: all unit_y_i=0xFFFFFFFF -> y_o=34'h3_FFFF_FFFC, no wrap.
- Timeout: TIMEOUT_CYCLES=64, unit 2 never sends done -> err_o=1 after 64 WAIT cycles, no y_valid_o, chain unchanged, sample_ready_o=1. err_clr_i pulse -> err_o=0.
- Backpressure/reset: sample_valid_i held high during WAIT -> sample_ready_o=0, exactly one acceptance per transaction. A stray done in IDLE is ignored. rst_ni low during SUM -> IDLE, y_o=0, no y_valid_o pulse.
